arc4_encrypt: RTL

//  Writer-side counterpart of the brute-force key cracker. Reads a length-prefixed

---
 rtl/arc4_pkg.sv | 46 ++++
 rtl/arc4_encrypt_if.sv | 25 ++
 rtl/s_mem.sv | 18 +
 rtl/arc4_encrypt.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types, constants and helpers for the ARC4 encryptor.
package arc4_pkg;

  localparam int unsigned KEYLEN = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEY_W  = BYTE_W * KEYLEN;
  localparam int unsigned CNT_W  = 9;

  localparam logic [BYTE_W-1:0] ASCII_MIN = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    IDLE,
    RDLEN,
    WRLEN,
    INIT,
    KSA_RDI,
    KSA_RDJ,
    KSA_WRI,
    KSA_WRJ,
    PRGA_RDI,
    PRGA_RDJ,
    PRGA_WRI,
    PRGA_WRJ,
    PRGA_RDP,
    PRGA_XOR,
    DONE
  } state_e;

  // Key byte idx, most significant byte first.
  function automatic logic [BYTE_W-1:0] keybyte(input logic [KEY_W-1:0] key,
                                                input logic [1:0]       idx);
    logic [BYTE_W-1:0] b;
    b = key[KEY_W-1 -: BYTE_W];
    for (int unsigned n = 0; n < KEYLEN; n++) begin
      if (idx == 2'(n)) b = key[KEY_W-1-BYTE_W*n -: BYTE_W];
    end
    return b;
  endfunction

  // True when the byte can be recovered by the cracker.
  function automatic logic is_printable(input logic [BYTE_W-1:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake, plaintext-read and ciphertext-write bus of the ARC4 encryptor.
interface arc4_encrypt_if;
  import arc4_pkg::*;

  logic              en;
  logic              rdy;
  logic [KEY_W-1:0]  key;
  logic [BYTE_W-1:0] pt_addr;
  logic [BYTE_W-1:0] pt_rddata;
  logic [BYTE_W-1:0] ct_addr;
  logic [BYTE_W-1:0] ct_wrdata;
  logic              ct_wren;
  logic              bad_char;

  modport master (
    output en, key, pt_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, bad_char
  );

  modport slave (
    input  en, key, pt_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, bad_char
  );

endinterface

// File: rtl/s_mem.sv
// 256x8 single-port RAM holding the ARC4 S-box; synchronous read, 1-cycle latency.
module s_mem (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wrdata,
  input  logic       wren,
  output logic [7:0] rddata
);

  logic [7:0] mem [256];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    rddata <= mem[addr];
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, writes the length-prefixed ciphertext.
module arc4_encrypt
  import arc4_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  arc4_encrypt_if.slave io
);

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [BYTE_W-1:0]   len_q, len_d;
  logic [BYTE_W-1:0]   i_q, i_d;
  logic [BYTE_W-1:0]   j_q, j_d;
  logic [BYTE_W-1:0]   si_q, si_d;
  logic [BYTE_W-1:0]   sj_q, sj_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          kidx_q, kidx_d;
  logic                rdy_q, rdy_d;
  logic [BYTE_W-1:0]   pt_addr_q, pt_addr_d;
  logic [BYTE_W-1:0]   ct_addr_q, ct_addr_d;
  logic [BYTE_W-1:0]   ct_wrdata_q, ct_wrdata_d;
  logic                ct_wren_q, ct_wren_d;
  logic                bad_q, bad_d;

  logic [BYTE_W-1:0]   s_addr_c, s_wrdata_c, s_rddata, j_next_c;
  logic                s_wren_c;

  s_mem u_s_mem (
    .clk    (clk),
    .addr   (s_addr_c),
    .wrdata (s_wrdata_c),
    .wren   (s_wren_c),
    .rddata (s_rddata)
  );

  // Next-state, S-box port mux and output computation.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    len_d       = len_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    cnt_d       = cnt_q;
    kidx_d      = kidx_q;
    rdy_d       = 1'b0;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    bad_d       = bad_q;
    s_addr_c    = i_q;
    s_wrdata_c  = '0;
    s_wren_c    = 1'b0;
    j_next_c    = j_q;

    unique case (state_q)
      IDLE, DONE: begin
        rdy_d = 1'b1;
        if (io.en && rdy_q) begin
          key_d     = io.key;
          bad_d     = 1'b0;
          rdy_d     = 1'b0;
          pt_addr_d = '0;
          state_d   = RDLEN;
        end
      end
      RDLEN: state_d = WRLEN;
      WRLEN: begin
        len_d       = io.pt_rddata;
        ct_addr_d   = '0;
        ct_wrdata_d = io.pt_rddata;
        ct_wren_d   = 1'b1;
        cnt_d       = '0;
        state_d     = (io.pt_rddata == '0) ? DONE : INIT;
      end
      INIT: begin
        s_addr_c   = cnt_q[BYTE_W-1:0];
        s_wrdata_c = cnt_q[BYTE_W-1:0];
        s_wren_c   = 1'b1;
        cnt_d      = cnt_q + 9'd1;
        if (cnt_q == 9'd255) begin
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = KSA_RDI;
        end
      end
      KSA_RDI: state_d = KSA_RDJ;
      KSA_RDJ: begin
        si_d     = s_rddata;
        j_next_c = j_q + s_rddata + keybyte(key_q, kidx_q);
        j_d      = j_next_c;
        s_addr_c = j_next_c;
        state_d  = KSA_WRI;
      end
      KSA_WRI: begin
        s_wrdata_c = s_rddata;
        s_wren_c   = 1'b1;
        state_d    = KSA_WRJ;
      end
      KSA_WRJ: begin
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
        i_d        = i_q + 8'd1;
        kidx_d     = (kidx_q == 2'(KEYLEN - 1)) ? 2'd0 : kidx_q + 2'd1;
        cnt_d      = cnt_q + 9'd1;
        state_d    = KSA_RDI;
        if (cnt_q == 9'd255) begin
          i_d     = '0;
          j_d     = '0;
          cnt_d   = 9'd1;
          state_d = PRGA_RDI;
        end
      end
      PRGA_RDI: begin
        i_d       = i_q + 8'd1;
        s_addr_c  = i_q + 8'd1;
        pt_addr_d = cnt_q[BYTE_W-1:0];
        state_d   = PRGA_RDJ;
      end
      PRGA_RDJ: begin
        si_d     = s_rddata;
        j_next_c = j_q + s_rddata;
        j_d      = j_next_c;
        s_addr_c = j_next_c;
        state_d  = PRGA_WRI;
      end
      PRGA_WRI: begin
        s_wrdata_c = s_rddata;
        s_wren_c   = 1'b1;
        sj_d       = s_rddata;
        state_d    = PRGA_WRJ;
      end
      PRGA_WRJ: begin
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
        state_d    = PRGA_RDP;
      end
      PRGA_RDP: begin
        s_addr_c = si_q + sj_q;
        state_d  = PRGA_XOR;
      end
      PRGA_XOR: begin
        ct_addr_d   = cnt_q[BYTE_W-1:0];
        ct_wrdata_d = s_rddata ^ io.pt_rddata;
        ct_wren_d   = 1'b1;
        if (!is_printable(io.pt_rddata)) bad_d = 1'b1;
        cnt_d       = cnt_q + 9'd1;
        state_d     = (cnt_q == {1'b0, len_q}) ? DONE : PRGA_RDI;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      len_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      cnt_q       <= '0;
      kidx_q      <= '0;
      rdy_q       <= 1'b0;
      pt_addr_q   <= '0;
      ct_addr_q   <= '0;
      ct_wrdata_q <= '0;
      ct_wren_q   <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      len_q       <= len_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      cnt_q       <= cnt_d;
      kidx_q      <= kidx_d;
      rdy_q       <= rdy_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      bad_q       <= bad_d;
    end
  end

  assign io.rdy       = rdy_q;
  assign io.pt_addr   = pt_addr_q;
  assign io.ct_addr   = ct_addr_q;
  assign io.ct_wrdata = ct_wrdata_q;
  assign io.ct_wren   = ct_wren_q;
  assign io.bad_char  = bad_q;

endmodule
